// File: rtl/fetch_queue.sv
// Instruction fetch queue: credit-based fetch of one word per cycle into a DEPTH-entry FIFO, flushed by Redirect.
// Optional macro FETCH_QUEUE_STATS_EN adds the saturating Discard_Count output.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst,
  output logic        IMem_Req,
  output logic [31:0] IMem_Addr,
  input  logic [31:0] IMem_Data,
  input  logic        Redirect,
  input  logic [31:0] Redirect_PC,
  output logic        Out_Valid,
  input  logic        Out_Ready,
  output logic [31:0] Out_Instruction,
  output logic [31:0] Out_PCPlus4,
  output logic [4:0]  Count
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [15:0] Discard_Count
`endif
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } entry_t;

  entry_t [DEPTH-1:0] mem;
  logic [31:0]        fetch_pc, inflight_pc4;
  logic               in_flight;
  logic [PW-1:0]      rd_ptr, wr_ptr;
  logic [4:0]         count;
  logic [5:0]         credit_used;
  logic               push, pop;
  logic               unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^Redirect_PC[1:0];

  // Occupancy plus the outstanding response; a request is only issued while a slot is guaranteed.
  assign credit_used = {1'b0, count} + {5'd0, in_flight};
  assign IMem_Req    = Rst && !Redirect && (credit_used < 6'(DEPTH));
  assign IMem_Addr   = fetch_pc;

  assign push = in_flight && !Redirect;
  assign pop  = Out_Valid && Out_Ready && !Redirect;

  assign Out_Valid       = (count != 5'd0);
  assign Out_Instruction = mem[rd_ptr].instr;
  assign Out_PCPlus4     = mem[rd_ptr].pc4;
  assign Count           = count;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      fetch_pc     <= {RESET_PC[31:2], 2'b00};
      inflight_pc4 <= 32'd0;
      in_flight    <= 1'b0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= 5'd0;
    end else begin
      // IMem_Req is low during Redirect, so this also kills the next-cycle response.
      in_flight <= IMem_Req;
      if (IMem_Req) begin
        fetch_pc     <= fetch_pc + 32'd4;
        inflight_pc4 <= fetch_pc + 32'd4;
      end
      if (Redirect) begin
        fetch_pc <= {Redirect_PC[31:2], 2'b00};
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= 5'd0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + 5'd1;
          2'b01:   count <= count - 5'd1;
          default: count <= count;
        endcase
      end
    end
  end

  // Payload storage needs no reset: Out_Valid qualifies it.
  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr] <= '{instr: IMem_Data, pc4: inflight_pc4};
  end

`ifdef FETCH_QUEUE_STATS_EN
  logic [16:0] discard_sum;
  assign discard_sum = {1'b0, Discard_Count} + 17'(credit_used);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)          Discard_Count <= 16'd0;
    else if (Redirect) Discard_Count <= discard_sum[16] ? 16'hFFFF : discard_sum[15:0];
  end
`endif

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge Clk) disable iff (!Rst)
    !(push && !pop && (count == 5'(DEPTH))))
    else $error("fetch_queue: push into full queue");
`endif

endmodule
